// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier with a start/ready/done handshake.
// One partial-product add per cycle through a WIDTH-bit ripple full adder;
// the 2*WIDTH-bit product appears after WIDTH compute cycles.

// WIDTH-bit ripple-carry full adder.
module full_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // Ripple the carry from bit 0 upward.
    always_comb begin
        logic c;
        c   = c_in;
        sum = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        c_out = c;
    end

endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [2*WIDTH-1:0] acc_shifted;

    // Multiplier LSB selects whether the multiplicand or zero is added.
    assign add_b = acc_q[0] ? mcand_q : '0;

    full_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (acc_q[2*WIDTH-1:WIDTH]),
        .b     (add_b),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    assign acc_shifted = {add_cout, add_sum, acc_q[WIDTH-1:1]};
    assign product     = product_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Next-state, datapath updates and handshake decode.
    // product is loaded on the edge entering DONE so it is already valid while done is high.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    mcand_d = a;
                    acc_d   = {{WIDTH{1'b0}}, b};
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy    = 1'b1;
                acc_d   = acc_shifted;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    product_d = acc_shifted;
                    state_d   = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=4): directed scenarios
// plus exhaustive and randomized operands compared against plain a*b.
`timescale 1ns/1ps
module tb_shift_add_multiplier;

    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               ready;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    shift_add_multiplier #(
        .WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for done; returns cycles waited.
    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < max_cyc) begin
            step();
            cyc++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
    endtask

    // Launch one multiplication and check busy length, done and product.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit scramble);
        int bc;
        int w;
        logic [2*WIDTH-1:0] expect_p;
        expect_p = (2*WIDTH)'(int'(x) * int'(y));
        w = 0;
        while (ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        start = 1'b1;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        if (scramble) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
        end
        bc = 0;
        while (busy === 1'b1 && bc < 50) begin
            step();
            bc++;
        end
        check("busy_len", bc, WIDTH);
        check("done", {29'b0, ready, busy, done}, 32'b001);
        check($sformatf("prod_%0d_%0d", x, y), {24'b0, product}, {24'b0, expect_p});
        step();
        check("after_done", {29'b0, ready, busy, done}, 32'b100);
    endtask

    initial begin
        int c;
        int base;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // 1 Reset
        step();
        step();
        rst = 1'b0;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_product", {24'b0, product}, 32'h00);

        // 2 Basic
        base = done_cnt;
        run_op(4'd3, 4'd5, 1'b0);
        repeat (10) step();
        check("basic_hold", {24'b0, product}, 32'h0F);
        check("basic_pulses", done_cnt - base, 1);

        // 3 Extremes
        run_op(4'd15, 4'd15, 1'b0);
        run_op(4'd0, 4'd9, 1'b0);
        run_op(4'd1, 4'd15, 1'b0);
        run_op(4'd8, 4'd2, 1'b0);

        // 4 Start while busy is ignored
        base  = done_cnt;
        start = 1'b1;
        a     = 4'd2;
        b     = 4'd3;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        a     = 4'd7;
        b     = 4'd7;
        step();
        start = 1'b0;
        wait_done(20, c);
        check("ignored_prod", {24'b0, product}, 32'h06);
        repeat (12) step();
        check("ignored_pulses", done_cnt - base, 1);

        // 5 Reset mid-operation
        base  = done_cnt;
        start = 1'b1;
        a     = 4'd15;
        b     = 4'd15;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_ready", {31'b0, ready}, 32'd1);
        check("midrst_product", {24'b0, product}, 32'h00);
        repeat (10) step();
        check("midrst_pulses", done_cnt - base, 0);
        run_op(4'd6, 4'd7, 1'b0);

        // 6 Back-to-back with start held high
        start = 1'b1;
        a     = 4'd5;
        b     = 4'd5;
        step();
        step();
        a = 4'd9;
        b = 4'd3;
        wait_done(20, c);
        check("b2b_first", {24'b0, product}, 32'h19);
        step();
        wait_done(20, c);
        start = 1'b0;
        check("b2b_spacing", c + 1, WIDTH + 2);
        check("b2b_second", {24'b0, product}, 32'h1B);
        step();

        // All operand pairs
        for (int i = 0; i < 256; i++) begin
            run_op(WIDTH'(i >> 4), WIDTH'(i), 1'b1);
        end

        // Random operands with random idle gaps
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 3)) step();
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
